// File: rtl/k6502_sequencer_pkg.sv
// Shared definitions for the k6502 sequencer: control-word field layout,
// address-mode encodings, cycle constants and the control-word decoder.
package k6502_sequencer_pkg;

    localparam int X_BITS = 8;

    // Bit positions of each field inside the mcode control word x
    localparam int X_ADDR_MODE  = 0;
    localparam int X_DL_LATCH_H = 1;
    localparam int X_DL_LATCH_L = 2;
    localparam int X_PC_LATCH_H = 3;
    localparam int X_PC_LATCH_L = 4;
    localparam int X_INC_DL     = 5;
    localparam int X_INC_PC     = 6;
    localparam int X_SYNC_NEXT  = 7;

    localparam int CYCLE_BITS = 6;
    localparam int ADDR_BITS  = 16;
    localparam int DATA_BITS  = 8;

    localparam logic [CYCLE_BITS-1:0] CYCLE_RESET = 6'b000000;
    localparam logic [CYCLE_BITS-1:0] CYCLE_FIRST = 6'b000001;

    typedef enum logic {
        ADDR_MODE_PC = 1'b0,
        ADDR_MODE_DL = 1'b1
    } addr_mode_e;

    typedef struct packed {
        addr_mode_e addr_mode;
        logic       dl_latch_h;
        logic       dl_latch_l;
        logic       pc_latch_h;
        logic       pc_latch_l;
        logic       inc_dl;
        logic       inc_pc;
        logic       sync_next;
    } ctrl_t;

    function automatic ctrl_t decode_x(input logic [X_BITS-1:0] x);
        ctrl_t c;
        c.addr_mode  = addr_mode_e'(x[X_ADDR_MODE]);
        c.dl_latch_h = x[X_DL_LATCH_H];
        c.dl_latch_l = x[X_DL_LATCH_L];
        c.pc_latch_h = x[X_PC_LATCH_H];
        c.pc_latch_l = x[X_PC_LATCH_L];
        c.inc_dl     = x[X_INC_DL];
        c.inc_pc     = x[X_INC_PC];
        c.sync_next  = x[X_SYNC_NEXT];
        return c;
    endfunction

endpackage

// File: rtl/k6502_sequencer_addr_reg.sv
// 16-bit address register (PC or DL): byte latches from the data bus take
// priority over the wrapping increment.
module k6502_addr_reg
    import k6502_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 latch_h,
    input  logic                 latch_l,
    input  logic                 inc,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [ADDR_BITS-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (en) begin
            if (latch_h || latch_l) begin
                if (latch_h) value[ADDR_BITS-1:DATA_BITS] <= data_in;
                if (latch_l) value[DATA_BITS-1:0]         <= data_in;
            end else if (inc) begin
                value <= value + 16'd1;
            end
        end
    end

endmodule

// File: rtl/k6502_sequencer.sv
// k6502 instruction sequencer and address datapath: drives {ir, cycle} to the
// mcode ROM and executes the returned control word. Optional stall input
// via macro K6502_RDY_EN.
module k6502_sequencer
    import k6502_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [X_BITS-1:0]     x,
    input  logic [DATA_BITS-1:0]  data_in,
`ifdef K6502_RDY_EN
    input  logic                  rdy,
`endif
    output logic [DATA_BITS-1:0]  ir,
    output logic [CYCLE_BITS-1:0] cycle,
    output logic [ADDR_BITS-1:0]  addr,
    output logic                  sync,
    output logic [ADDR_BITS-1:0]  pc,
    output logic [ADDR_BITS-1:0]  dl,
    output logic                  seq_fault
);

    ctrl_t ctrl;
    logic  en;

    assign ctrl = decode_x(x);

`ifdef K6502_RDY_EN
    assign en = rdy;
`else
    assign en = 1'b1;
`endif

    // addr uses the pre-update PC/DL, so a fetch sees the un-incremented PC
    assign addr = (ctrl.addr_mode == ADDR_MODE_PC) ? pc : dl;
    assign sync = ctrl.sync_next;

    k6502_addr_reg u_pc (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .latch_h (ctrl.pc_latch_h),
        .latch_l (ctrl.pc_latch_l),
        .inc     (ctrl.inc_pc),
        .data_in (data_in),
        .value   (pc)
    );

    k6502_addr_reg u_dl (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .latch_h (ctrl.dl_latch_h),
        .latch_l (ctrl.dl_latch_l),
        .inc     (ctrl.inc_dl),
        .data_in (data_in),
        .value   (dl)
    );

    // A cleared or exhausted cycle counter without a fetch is an overflow;
    // the zeroed IR/cycle make mcode present the reset row, which refetches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir        <= '0;
            cycle     <= CYCLE_RESET;
            seq_fault <= 1'b0;
        end else if (en) begin
            if (ctrl.sync_next) begin
                ir    <= data_in;
                cycle <= CYCLE_FIRST;
            end else if ((cycle != CYCLE_RESET) && !cycle[CYCLE_BITS-1]) begin
                cycle <= cycle << 1;
            end else begin
                ir        <= '0;
                cycle     <= CYCLE_RESET;
                seq_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_k6502_sequencer.sv
// Directed plus randomized checks of k6502_sequencer against a step-count
// reference model of PC/DL/IR/cycle/fault behaviour.
module tb_k6502_sequencer;
    import k6502_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [X_BITS-1:0] x;
    logic [7:0]        data_in;
    logic              rdy;
    logic [7:0]        ir;
    logic [5:0]        cycle;
    logic [15:0]       addr;
    logic              sync;
    logic [15:0]       pc;
    logic [15:0]       dl;
    logic              seq_fault;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [15:0] m_pc, m_dl;
    logic [7:0]  m_ir;
    int          m_step;
    logic        m_fault;

    always #5 clk = ~clk;

    k6502_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .data_in   (data_in),
`ifdef K6502_RDY_EN
        .rdy       (rdy),
`endif
        .ir        (ir),
        .cycle     (cycle),
        .addr      (addr),
        .sync      (sync),
        .pc        (pc),
        .dl        (dl),
        .seq_fault (seq_fault)
    );

    function automatic logic [X_BITS-1:0] mk(input bit am, input bit dlh, input bit dll,
                                             input bit pch, input bit pcl, input bit idl,
                                             input bit ipc, input bit sn);
        logic [X_BITS-1:0] v;
        v = '0;
        v[X_ADDR_MODE]  = am;
        v[X_DL_LATCH_H] = dlh;
        v[X_DL_LATCH_L] = dll;
        v[X_PC_LATCH_H] = pch;
        v[X_PC_LATCH_L] = pcl;
        v[X_INC_DL]     = idl;
        v[X_INC_PC]     = ipc;
        v[X_SYNC_NEXT]  = sn;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_cycle();
        return (m_step == 0) ? 6'd0 : 6'(1 << (m_step - 1));
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_dl = 16'h0000; m_ir = 8'h00; m_step = 0; m_fault = 1'b0;
    endtask

    function automatic logic [15:0] reg_next(input logic [15:0] cur, input bit lh, input bit ll,
                                             input bit inc, input logic [7:0] d);
        logic [15:0] n;
        n = cur;
        if (lh || ll) begin
            if (lh) n = (n & 16'h00FF) | ({8'h00, d} * 16'd256);
            if (ll) n = (n & 16'hFF00) | {8'h00, d};
        end else if (inc) begin
            n = 16'((32'(cur) + 1) % 65536);
        end
        return n;
    endfunction

    task automatic model_edge(input logic [X_BITS-1:0] xv, input logic [7:0] d, input bit r);
        bit en;
`ifdef K6502_RDY_EN
        en = r;
`else
        en = 1'b1;
`endif
        if (en) begin
            m_pc = reg_next(m_pc, xv[X_PC_LATCH_H], xv[X_PC_LATCH_L], xv[X_INC_PC], d);
            m_dl = reg_next(m_dl, xv[X_DL_LATCH_H], xv[X_DL_LATCH_L], xv[X_INC_DL], d);
            if (xv[X_SYNC_NEXT]) begin
                m_ir = d; m_step = 1;
            end else if (m_step >= 1 && m_step < 6) begin
                m_step = m_step + 1;
            end else begin
                m_ir = 8'h00; m_step = 0; m_fault = 1'b1;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ir"},    {8'h00, ir},     {8'h00, m_ir});
        chk({tag, ".cycle"}, {10'h000, cycle}, {10'h000, exp_cycle()});
        chk({tag, ".pc"},    pc,              m_pc);
        chk({tag, ".dl"},    dl,              m_dl);
        chk({tag, ".fault"}, {15'h0, seq_fault}, {15'h0, m_fault});
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".addr"}, addr, x[X_ADDR_MODE] ? m_dl : m_pc);
        chk({tag, ".sync"}, {15'h0, sync}, {15'h0, x[X_SYNC_NEXT]});
    endtask

    // called at posedge+1: drive, check comb paths, clock, check registers
    task automatic step(input string tag, input logic [X_BITS-1:0] xv,
                        input logic [7:0] d, input bit r);
        x = xv; data_in = d; rdy = r;
        #1;
        check_comb(tag);
        @(posedge clk);
        model_edge(xv, d, r);
        #1;
        check_regs(tag);
    endtask

    logic [X_BITS-1:0] reset_row, fetch_row, nop_c1, hold_row;

    initial begin
        reset_row = mk(0, 0, 0, 0, 0, 0, 0, 1);
        fetch_row = mk(0, 0, 0, 0, 0, 0, 1, 1);
        nop_c1    = mk(0, 0, 0, 0, 0, 0, 1, 0);
        hold_row  = mk(0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; x = reset_row; data_in = 8'hEA; rdy = 1'b1;
        model_reset();
        #2;
        check_regs("reset");
        chk("reset.addr", addr, 16'h0000);
        chk("reset.sync", {15'h0, sync}, 16'h0001);
        @(posedge clk); #1;
        reset = 1'b0;

        step("first_fetch", reset_row, 8'hEA, 1);
        chk("first_fetch.ir_ea", {8'h00, ir}, 16'h00EA);

        step("nop_c1", nop_c1, 8'h00, 1);
        step("nop_c2", reset_row, 8'h4C, 1);
        chk("nop.pc", pc, 16'h0001);
        chk("nop.cycle", {10'h0, cycle}, 16'h0001);

        // PC: latch wins over increment, then increment wraps
        step("pc_h", mk(0, 0, 0, 1, 0, 0, 0, 1), 8'h12, 1);
        step("pc_l", mk(0, 0, 0, 0, 1, 0, 0, 1), 8'hFF, 1);
        step("pc_latch_wins", mk(0, 0, 0, 0, 1, 0, 1, 1), 8'h34, 1);
        chk("pc_latch_wins.val", pc, 16'h1234);
        step("pc_ff", mk(0, 0, 0, 1, 1, 0, 0, 1), 8'hFF, 1);
        step("pc_wrap", mk(0, 0, 0, 0, 0, 0, 1, 1), 8'h00, 1);
        chk("pc_wrap.val", pc, 16'h0000);

        step("dl_h", mk(1, 1, 0, 0, 0, 0, 0, 1), 8'h12, 1);
        step("dl_l", mk(1, 0, 1, 0, 0, 0, 0, 1), 8'hFF, 1);
        step("dl_latch_wins", mk(1, 0, 1, 0, 0, 1, 0, 1), 8'h34, 1);
        chk("dl_latch_wins.val", dl, 16'h1234);
        step("dl_ff", mk(1, 1, 1, 0, 0, 0, 0, 1), 8'hFF, 1);
        step("dl_wrap", mk(1, 0, 0, 0, 0, 1, 0, 1), 8'h00, 1);
        chk("dl_wrap.val", dl, 16'h0000);

        step("dl_ab", mk(0, 1, 0, 0, 0, 0, 0, 1), 8'hAB, 1);
        step("dl_cd", mk(0, 0, 1, 0, 0, 0, 0, 1), 8'hCD, 1);
        x = mk(1, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("addr_dl_comb", addr, 16'hABCD);

        // cycle overflow after six non-fetch clocks from cycle 1
        for (int i = 0; i < 6; i++) step("overflow", hold_row, 8'h55, 1);
        chk("overflow.cycle", {10'h0, cycle}, 16'h0000);
        chk("overflow.fault", {15'h0, seq_fault}, 16'h0001);
        step("refetch", reset_row, 8'h4C, 1);
        chk("refetch.fault", {15'h0, seq_fault}, 16'h0001);

`ifdef K6502_RDY_EN
        step("jmp_c1", mk(0, 0, 0, 0, 0, 0, 1, 0), 8'h00, 1);
        for (int i = 0; i < 3; i++) step("stall", mk(0, 0, 1, 0, 0, 0, 1, 0), 8'h77, 0);
        step("resume", mk(0, 0, 1, 0, 0, 0, 1, 0), 8'h77, 1);
`endif

        // asynchronous reset mid-instruction, no clock edge needed
        step("pre_reset", nop_c1, 8'h00, 1);
        #2;
        reset = 1'b1; x = reset_row;
        model_reset();
        #1;
        check_regs("async_reset");
        chk("async_reset.addr", addr, 16'h0000);
        @(posedge clk); #1;
        check_regs("reset_held");
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [X_BITS-1:0] xr;
            bit rr;
            xr = X_BITS'($urandom);
            if ($urandom_range(0, 3) == 0) xr[X_SYNC_NEXT] = 1'b0;
            rr = ($urandom_range(0, 4) != 0);
            step("random", xr, 8'($urandom), rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
